// File: rtl/ifu_lsu_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_lsu_mem_arbiter_pkg
// Brief   : Shared encodings and widths for the IFU/LSU memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ifu_lsu_mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/ifu_lsu_mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pick
// Brief   : LSU-first winner select with an IFU starvation guard.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick #(
  parameter int IFU_MAX_SKIP = 4
) (
  input  logic cpu_clk,
  input  logic cpu_rs,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic idle,
  input  logic accept,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam logic [3:0] c_max_skip = 4'(IFU_MAX_SKIP);

  logic [3:0] r_skip_cnt;
  logic       w_skip_hit;
  logic       w_pick_lsu;
  logic       w_pick_ifu;

  // The IFU is forced through once the LSU has beaten it IFU_MAX_SKIP times in a row.
  assign w_skip_hit = ifu_valid && lsu_valid && (r_skip_cnt == c_max_skip);
  assign w_pick_lsu = lsu_valid && !w_skip_hit;
  assign w_pick_ifu = ifu_valid && !w_pick_lsu;

  assign grant_lsu = idle && w_pick_lsu;
  assign grant_ifu = idle && w_pick_ifu;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rs) begin
      r_skip_cnt <= 4'd0;
    end else if (accept) begin
      if (w_pick_ifu) begin
        r_skip_cnt <= 4'd0;
      end else if (ifu_valid && (r_skip_cnt != 4'hF)) begin
        r_skip_cnt <= r_skip_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_lsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ifu_lsu_mem_arbiter
// Brief   : Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Revision: 1.0 - initial release
// ============================================================================
module ifu_lsu_mem_arbiter
  import ifu_lsu_mem_arbiter_pkg::*;
#(
  parameter int IFU_MAX_SKIP   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rs,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rsp_rdata,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

  arb_state_t        r_state;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [15:0]       r_tmo;
  logic              r_mem_req_valid;
  logic              r_ifu_rsp_valid;
  logic              r_lsu_rsp_valid;

  logic        w_idle;
  logic        w_accept;
  logic        w_grant_ifu;
  logic        w_grant_lsu;
  logic        w_rsp_done;
  logic [15:0] w_tmo_next;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && (ifu_req_valid || lsu_req_valid);
  assign w_tmo_next = r_tmo + 16'd1;
  assign w_rsp_done = (r_ifu_rsp_valid && ifu_rsp_ready) || (r_lsu_rsp_valid && lsu_rsp_ready);

  mem_arb_pick #(
    .IFU_MAX_SKIP (IFU_MAX_SKIP)
  ) u_pick (
    .cpu_clk   (cpu_clk),
    .cpu_rs    (cpu_rs),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .idle      (w_idle),
    .accept    (w_accept),
    .grant_ifu (w_grant_ifu),
    .grant_lsu (w_grant_lsu)
  );

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  // Stale responses in IDLE/GRANT are swallowed rather than back-pressured.
  assign mem_rsp_ready = (r_state != ST_RESP);

  assign ifu_rsp_valid = r_ifu_rsp_valid;
  assign ifu_rsp_data  = r_ifu_rsp_valid ? r_rsp_data : '0;
  assign ifu_rsp_err   = r_ifu_rsp_valid && r_rsp_err;
  assign lsu_rsp_valid = r_lsu_rsp_valid;
  assign lsu_rsp_rdata = r_lsu_rsp_valid ? r_rsp_data : '0;
  assign lsu_rsp_err   = r_lsu_rsp_valid && r_rsp_err;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rs) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWN_IFU;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_rsp_data      <= '0;
      r_rsp_err       <= 1'b0;
      r_tmo           <= 16'd0;
      r_mem_req_valid <= 1'b0;
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_grant_lsu) begin
              r_owner <= OWN_LSU;
              r_addr  <= lsu_req_addr;
              r_wen   <= lsu_req_wen;
              r_wdata <= lsu_req_wdata;
              r_wmask <= lsu_req_wmask;
            end else begin
              r_owner <= OWN_IFU;
              r_addr  <= ifu_req_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_tmo           <= 16'd0;
            r_state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real response beats a timeout expiring in the same cycle.
          if (mem_rsp_valid || (w_tmo_next == c_timeout)) begin
            r_rsp_data      <= (mem_rsp_valid && !r_wen) ? mem_rsp_rdata : '0;
            r_rsp_err       <= mem_rsp_valid ? mem_rsp_err : 1'b1;
            r_ifu_rsp_valid <= (r_owner == OWN_IFU);
            r_lsu_rsp_valid <= (r_owner == OWN_LSU);
            r_state         <= ST_RESP;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_lsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_lsu_mem_arbiter
// Brief   : Directed self-checking bench for ifu_lsu_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifu_lsu_mem_arbiter;
  import ifu_lsu_mem_arbiter_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rs;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  ifu_lsu_mem_arbiter #(
    .IFU_MAX_SKIP   (4),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .cpu_clk       (cpu_clk),
    .cpu_rs        (cpu_rs),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // One full transaction from an idle cycle; response appears 3 cycles after accept.
  task automatic run_vec(input vec_t v);
    step();
    ifu_req_valid = !v.is_lsu;
    lsu_req_valid = v.is_lsu;
    ifu_req_addr  = v.addr;
    lsu_req_addr  = v.addr;
    lsu_req_wen   = v.wen;
    lsu_req_wdata = v.wdata;
    lsu_req_wmask = v.wmask;
    #1;
    chk("req_ready", 32'(v.is_lsu ? lsu_req_ready : ifu_req_ready), 32'd1);
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mem_req_addr", mem_req_addr, v.addr);
    chk("mem_req_wen", 32'(mem_req_wen), 32'(v.exp_wen));
    chk("mem_req_wdata", mem_req_wdata, v.exp_wdata);
    chk("mem_req_wmask", 32'(mem_req_wmask), 32'(v.exp_wmask));
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = v.m_rdata;
    mem_rsp_err   = v.m_err;
    chk("mem_rsp_ready_wait", 32'(mem_rsp_ready), 32'd1);
    step();
    mem_rsp_valid = 1'b0;
    chk("rsp_valid_pair", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, v.is_lsu ? 32'd1 : 32'd2);
    chk("rsp_data", v.is_lsu ? lsu_rsp_rdata : ifu_rsp_data, v.exp_data);
    chk("rsp_err", 32'(v.is_lsu ? lsu_rsp_err : ifu_rsp_err), 32'(v.exp_err));
    ifu_rsp_ready = !v.is_lsu;
    lsu_rsp_ready = v.is_lsu;
    step();
    ifu_rsp_ready = 1'b0;
    lsu_rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] order;
    int         k;
    logic       seen;

    vecs[0] = '{is_lsu:1'b0, addr:RESET_PC, wen:1'b1, wdata:32'h5555_AAAA, wmask:4'hF,
                m_rdata:32'h0000_0413, m_err:1'b0, exp_wen:1'b0, exp_wdata:32'h0,
                exp_wmask:4'h0, exp_data:32'h0000_0413, exp_err:1'b0};
    vecs[1] = '{is_lsu:1'b1, addr:32'h8000_1000, wen:1'b1, wdata:32'hDEAD_BEEF, wmask:4'b0011,
                m_rdata:32'h1234_5678, m_err:1'b0, exp_wen:1'b1, exp_wdata:32'hDEAD_BEEF,
                exp_wmask:4'b0011, exp_data:32'h0, exp_err:1'b0};
    vecs[2] = '{is_lsu:1'b1, addr:32'h8000_2004, wen:1'b0, wdata:32'h0, wmask:4'hF,
                m_rdata:32'hCAFE_F00D, m_err:1'b0, exp_wen:1'b0, exp_wdata:32'h0,
                exp_wmask:4'hF, exp_data:32'hCAFE_F00D, exp_err:1'b0};
    vecs[3] = '{is_lsu:1'b0, addr:32'h8000_0004, wen:1'b0, wdata:32'h0, wmask:4'h0,
                m_rdata:32'h0010_0073, m_err:1'b1, exp_wen:1'b0, exp_wdata:32'h0,
                exp_wmask:4'h0, exp_data:32'h0010_0073, exp_err:1'b1};
    vecs[4] = '{is_lsu:1'b1, addr:32'h8000_3008, wen:1'b0, wdata:32'h0, wmask:4'b1100,
                m_rdata:32'hA5A5_0000, m_err:1'b1, exp_wen:1'b0, exp_wdata:32'h0,
                exp_wmask:4'b1100, exp_data:32'hA5A5_0000, exp_err:1'b1};

    cpu_rs = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
    step();
    step();
    cpu_rs = 1'b0;
    chk("reset_valids", {27'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid,
                         ifu_req_ready, lsu_req_ready}, 32'd0);
    chk("reset_mem_addr", mem_req_addr, 32'd0);
    chk("reset_rsp_data", ifu_rsp_data | lsu_rsp_rdata, 32'd0);
    chk("reset_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesting continuously: LSU x4, then IFU forced, then LSU again.
    order = 6'b01_0000;
    step();
    ifu_req_valid = 1'b1; ifu_req_addr = RESET_PC;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'hF;
    ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      #1;
      chk("grant_ready", {30'd0, ifu_req_ready, lsu_req_ready}, order[r] ? 32'd2 : 32'd1);
      step();
      mem_req_ready = 1'b1;
      chk("grant_wen", 32'(mem_req_wen), 32'(!order[r]));
      chk("no_ready_in_grant", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'(r); mem_rsp_err = 1'b0;
      step();
      mem_rsp_valid = 1'b0;
      chk("grant_owner_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, order[r] ? 32'd2 : 32'd1);
      step();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;

    // Memory never answers: error after 16 WAIT cycles, later stray response dropped.
    step();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    k = 0;
    while (!ifu_rsp_valid && k < 40) begin
      step();
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'd16);
    chk("timeout_data", ifu_rsp_data, 32'd0);
    chk("timeout_err", 32'(ifu_rsp_err), 32'd1);
    chk("timeout_lsu_quiet", 32'(lsu_rsp_valid), 32'd0);
    ifu_rsp_ready = 1'b1;
    step();
    ifu_rsp_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stale_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    step();
    mem_rsp_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | ifu_rsp_valid | lsu_rsp_valid | mem_req_valid;
      step();
    end
    chk("stale_dropped", 32'(seen), 32'd0);

    // IFU response back-pressured while the LSU waits.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0513; mem_rsp_err = 1'b0;
    step();
    mem_rsp_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_4000; lsu_req_wen = 1'b0; lsu_req_wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ifu_valid", 32'(ifu_rsp_valid), 32'd1);
      chk("bp_ifu_data", ifu_rsp_data, 32'h0000_0513);
      chk("bp_lsu_ready", 32'(lsu_req_ready), 32'd0);
      chk("bp_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
      step();
    end
    ifu_rsp_ready = 1'b1;
    step();
    ifu_rsp_ready = 1'b0;
    #1;
    chk("bp_ifu_cleared", 32'(ifu_rsp_valid), 32'd0);
    chk("bp_lsu_accept", 32'(lsu_req_ready), 32'd1);
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    chk("bp_lsu_addr", mem_req_addr, 32'h8000_4000);
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1122_3344;
    step();
    mem_rsp_valid = 1'b0;
    chk("bp_lsu_rdata", lsu_rsp_rdata, 32'h1122_3344);
    lsu_rsp_ready = 1'b1;
    step();
    lsu_rsp_ready = 1'b0;

    // Reset pulse in WAIT abandons the transaction.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0030;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; cpu_rs = 1'b1;
    step();
    cpu_rs = 1'b0;
    chk("rst_wait_valids", {27'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid,
                            ifu_req_ready, lsu_req_ready}, 32'd0);
    chk("rst_wait_addr", mem_req_addr, 32'd0);
    chk("rst_wait_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_0001;
    step();
    mem_rsp_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | ifu_rsp_valid | lsu_rsp_valid;
      step();
    end
    chk("rst_late_dropped", 32'(seen), 32'd0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
